im_fetch_sequencer: RTL and testbench

Instruction-fetch sequencer between the program counter logic and `Instruction_Memory`. It owns the fetch PC, drives `A_IM` and captures `RD_IM` into a small prefetch FIFO. It presents instructions to decode over a valid/ready handshake and services redirects from branch/jump resolution by flushing the FIFO and restarting fetch.

---
 rtl/im_fetch_sequencer.sv | 129 ++++++++++++
 tb/tb_im_fetch_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/im_fetch_sequencer.sv
// rtl/im_fetch_sequencer.sv - instruction-fetch sequencer with prefetch FIFO and redirect handling
//
// Parameters: RESET_PC (word-aligned reset fetch PC), BUF_DEPTH (power of two, 2..8)
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect halts fetch and sets MISALIGN)
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   EN_FETCH                 run enable
//   A_IM / RD_IM             combinational instruction memory address / data
//   REDIR_VALID / REDIR_PC   one-cycle redirect request and target
//   INSTR_VALID / INSTR / INSTR_PC / INSTR_READY   decode handshake at FIFO head
//   FETCH_CNT                instructions accepted by decode
//   MISALIGN                 sticky misaligned-redirect flag
module im_fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN_FETCH,
    output logic [31:0] A_IM,
    input  logic [31:0] RD_IM,
    input  logic        REDIR_VALID,
    input  logic [31:0] REDIR_PC,
    output logic        INSTR_VALID,
    output logic [31:0] INSTR,
    output logic [31:0] INSTR_PC,
    input  logic        INSTR_READY,
    output logic [31:0] FETCH_CNT,
    output logic        MISALIGN
);

    localparam int            PW    = $clog2(BUF_DEPTH);
    localparam logic [PW:0]   DEPTH = (PW + 1)'(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   buf_instr [BUF_DEPTH];
    logic [31:0]   buf_pc    [BUF_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          misalign_q;

    logic pop;
    logic push;
    logic redir_take;
    logic redir_bad;

    assign A_IM        = fetch_pc;
    assign INSTR_VALID = (count != '0) && (state != HALT);
    assign INSTR       = buf_instr[rd_ptr];
    assign INSTR_PC    = buf_pc[rd_ptr];
    assign MISALIGN    = misalign_q;

    assign pop  = INSTR_VALID && INSTR_READY;
    // A full FIFO still accepts a new word when the head leaves in the same cycle.
    assign push = (state == RUN) && EN_FETCH && !REDIR_VALID && ((count < DEPTH) || pop);

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_take = REDIR_VALID && (state != HALT) && (REDIR_PC[1:0] == 2'b00);
    assign redir_bad  = REDIR_VALID && (state != HALT) && (REDIR_PC[1:0] != 2'b00);
`else
    logic unused_redir_lsb;
    assign unused_redir_lsb = &{1'b0, REDIR_PC[1:0]};
    assign redir_take = REDIR_VALID && (state != HALT);
    assign redir_bad  = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            FETCH_CNT  <= 32'd0;
            misalign_q <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_instr[i] <= 32'd0;
                buf_pc[i]    <= 32'd0;
            end
        end else begin
            case (state)
                IDLE:    if (EN_FETCH)  state <= RUN;
                RUN:     if (!EN_FETCH) state <= IDLE;
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase

            if (redir_take || redir_bad) begin
                // Redirect wins over push and pop: in-flight words are stale
                // and a same-cycle accept is dropped without counting.
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                if (redir_take) begin
                    fetch_pc <= {REDIR_PC[31:2], 2'b00};
                end
                if (redir_bad) begin
                    misalign_q <= 1'b1;
                    state      <= HALT;
                end
            end else begin
                if (push) begin
                    buf_instr[wr_ptr] <= RD_IM;
                    buf_pc[wr_ptr]    <= fetch_pc;
                    wr_ptr            <= wr_ptr + 1'b1;
                    fetch_pc          <= fetch_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr    <= rd_ptr + 1'b1;
                    FETCH_CNT <= FETCH_CNT + 32'd1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_im_fetch_sequencer.sv
// tb/tb_im_fetch_sequencer.sv - scoreboard testbench for im_fetch_sequencer
module tb_im_fetch_sequencer;

    localparam logic [31:0] K = 32'h5A5A_C3C3;

    logic        CLK = 1'b0;
    logic        RST, EN_FETCH, REDIR_VALID, INSTR_READY;
    logic [31:0] REDIR_PC;
    logic [31:0] A_IM, RD_IM, INSTR, INSTR_PC, FETCH_CNT;
    logic        INSTR_VALID, MISALIGN;
    logic [31:0] w_A_IM, w_RD_IM, w_INSTR, w_INSTR_PC, w_FETCH_CNT;
    logic        w_INSTR_VALID, w_MISALIGN;

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] snap;
    logic [31:0] a_snap;

    always #5 CLK = ~CLK;

    assign RD_IM   = A_IM ^ K;
    assign w_RD_IM = w_A_IM ^ K;

    im_fetch_sequencer #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .CLK(CLK), .RST(RST), .EN_FETCH(EN_FETCH), .A_IM(A_IM), .RD_IM(RD_IM),
        .REDIR_VALID(REDIR_VALID), .REDIR_PC(REDIR_PC), .INSTR_VALID(INSTR_VALID),
        .INSTR(INSTR), .INSTR_PC(INSTR_PC), .INSTR_READY(INSTR_READY),
        .FETCH_CNT(FETCH_CNT), .MISALIGN(MISALIGN)
    );

    im_fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut_w (
        .CLK(CLK), .RST(RST), .EN_FETCH(EN_FETCH), .A_IM(w_A_IM), .RD_IM(w_RD_IM),
        .REDIR_VALID(REDIR_VALID), .REDIR_PC(REDIR_PC), .INSTR_VALID(w_INSTR_VALID),
        .INSTR(w_INSTR), .INSTR_PC(w_INSTR_PC), .INSTR_READY(INSTR_READY),
        .FETCH_CNT(w_FETCH_CNT), .MISALIGN(w_MISALIGN)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_seq(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    // Scoreboard: every accepted head must be the next expected PC/word.
    always @(negedge CLK) begin
        if (!RST && !REDIR_VALID && INSTR_VALID && INSTR_READY) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("acc_pc", INSTR_PC, e);
                check("acc_instr", INSTR, e ^ K);
                acc_cnt++;
            end
        end
    end

    initial begin
        RST = 1'b1; EN_FETCH = 1'b0; INSTR_READY = 1'b0;
        REDIR_VALID = 1'b0; REDIR_PC = 32'd0;
        repeat (2) step();
        check("rst_a_im", A_IM, 32'd0);
        check("rst_valid", INSTR_VALID, 32'd0);
        check("rst_instr", INSTR, 32'd0);
        check("rst_instr_pc", INSTR_PC, 32'd0);
        check("rst_cnt", FETCH_CNT, 32'd0);
        check("rst_misalign", MISALIGN, 32'd0);
        check("rst_w_a_im", w_A_IM, 32'hFFFF_FFF8);

        // First fetch after reset, free-running decode
        RST = 1'b0; EN_FETCH = 1'b1; INSTR_READY = 1'b1;
        load_seq(32'd0);
        acc_cnt = 0;
        check("c0_a_im", A_IM, 32'd0);
        check("c0_valid", INSTR_VALID, 32'd0);
        step();
        check("c1_a_im", A_IM, 32'd0);
        check("c1_valid", INSTR_VALID, 32'd0);
        step();
        check("c2_valid", INSTR_VALID, 32'd1);
        check("c2_pc", INSTR_PC, 32'd0);
        check("c2_a_im", A_IM, 32'd4);
        check("wrap_pc0", w_INSTR_PC, 32'hFFFF_FFF8);
        step();
        check("wrap_pc1", w_INSTR_PC, 32'hFFFF_FFFC);
        step();
        check("wrap_pc2", w_INSTR_PC, 32'h0000_0000);
        check("wrap_valid", w_INSTR_VALID, 32'd1);
        repeat (8) step();
        check("cnt10", FETCH_CNT, 32'd10);
        check("cnt10_model", FETCH_CNT, 32'(acc_cnt));
        check("c12_a_im", A_IM, 32'd44);

        // Reset mid-stream, then back-pressure from decode
        RST = 1'b1; INSTR_READY = 1'b0;
        step();
        check("rst_mid_cnt", FETCH_CNT, 32'd0);
        check("rst_mid_a_im", A_IM, 32'd0);
        RST = 1'b0;
        load_seq(32'd0);
        acc_cnt = 0;
        repeat (3) step();
        check("stall_a_im", A_IM, 32'd8);
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_hold_a_im", A_IM, 32'd8);
            check("stall_hold_pc", INSTR_PC, 32'd0);
            check("stall_hold_instr", INSTR, 32'd0 ^ K);
        end
        INSTR_READY = 1'b1;
        repeat (3) step();
        check("release_cnt", FETCH_CNT, 32'd3);
        check("release_model", FETCH_CNT, 32'(acc_cnt));

        // Redirect while full, with a same-cycle accept that must be dropped
        INSTR_READY = 1'b0;
        repeat (3) step();
        snap = 32'(acc_cnt);
        REDIR_VALID = 1'b1; REDIR_PC = 32'h100; INSTR_READY = 1'b1;
        load_seq(32'h100);
        step();
        REDIR_VALID = 1'b0;
        check("redir_bubble", INSTR_VALID, 32'd0);
        check("redir_cnt", FETCH_CNT, snap);
        step();
        check("redir_valid", INSTR_VALID, 32'd1);
        check("redir_pc", INSTR_PC, 32'h100);
        repeat (3) step();
        check("redir_model", FETCH_CNT, 32'(acc_cnt));

        // Misaligned redirect
        a_snap = A_IM;
        REDIR_VALID = 1'b1; REDIR_PC = 32'h102;
`ifdef FETCH_ALIGN_CHECK_EN
        exp_q.delete();
        step();
        REDIR_VALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("halt_valid", INSTR_VALID, 32'd0);
            check("halt_misalign", MISALIGN, 32'd1);
            step();
        end
        check("halt_a_im", A_IM, a_snap);
`else
        load_seq(32'h100);
        step();
        REDIR_VALID = 1'b0;
        check("mis_bubble", INSTR_VALID, 32'd0);
        step();
        check("mis_valid", INSTR_VALID, 32'd1);
        check("mis_pc", INSTR_PC, 32'h100);
        check("mis_flag", MISALIGN, 32'd0);
        check("mis_a_im_moved", 32'(A_IM != a_snap), 32'd1);
`endif
        RST = 1'b1;
        step();
        check("post_rst_misalign", MISALIGN, 32'd0);
        check("post_rst_valid", INSTR_VALID, 32'd0);
        RST = 1'b0; EN_FETCH = 1'b1; INSTR_READY = 1'b1;
        load_seq(32'd0);
        acc_cnt = 0;
        repeat (4) step();

        // Drop EN_FETCH mid-stream: FIFO drains, no new fetches
        INSTR_READY = 1'b0;
        repeat (2) step();
        EN_FETCH = 1'b0; INSTR_READY = 1'b1;
        a_snap = A_IM;
        repeat (4) step();
        check("drain_a_im", A_IM, a_snap);
        check("drain_valid", INSTR_VALID, 32'd0);
        check("drain_model", FETCH_CNT, 32'(acc_cnt));
        RST = 1'b1; REDIR_VALID = 1'b1; REDIR_PC = 32'h200;
        step();
        check("rst_redir_a_im", A_IM, 32'd0);
        check("rst_redir_valid", INSTR_VALID, 32'd0);
        check("rst_redir_cnt", FETCH_CNT, 32'd0);
        RST = 1'b0; REDIR_VALID = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
